// File: rtl/tt_bist_engine.sv
// tt_bist_engine
//   Built-in self-test engine that sits between the TinyTapeout pin wrapper and
//   the logic under test. When start is seen in IDLE or DONE, the engine issues
//   NUM_PATTERNS LFSR patterns on pat_out. It compacts the DUT responses, taken
//   LATENCY cycles after each pattern, into a MISR. It then compares the MISR
//   against expected_sig, so that one run produces one pass/fail bit.
//
// Ports
//   clk          in   1      clock
//   rst_n        in   1      synchronous reset, active low
//   ena          in   1      design enable; 0 freezes every register
//   start        in   1      run request (level), sampled in IDLE/DONE only
//   expected_sig in   WIDTH  golden signature
//   resp_in      in   WIDTH  response from the logic under test
//   pat_out      out  WIDTH  stimulus pattern
//   busy         out  1      high while patterns are issued or still in flight
//   done         out  1      high once the run has completed
//   pass         out  1      signature matched expected_sig (valid with done)
//   signature    out  WIDTH  MISR contents
module tt_bist_engine #(
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      NUM_PATTERNS = 255,
    parameter int unsigned      LATENCY      = 1,
    parameter logic [WIDTH-1:0] LFSR_TAPS    = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] MISR_TAPS    = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED         = WIDTH'(8'h01)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] expected_sig,
    input  logic [WIDTH-1:0] resp_in,
    output logic [WIDTH-1:0] pat_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    localparam int unsigned    CW   = $clog2(NUM_PATTERNS + 1);
    localparam logic [CW-1:0]  LAST = CW'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [CW-1:0]    cnt;
    // vpipe[0] marks "pat_out holds a freshly issued pattern"; each further
    // stage adds one cycle of DUT latency. The top stage enables compaction.
    logic [LATENCY:0] vpipe;
    logic [WIDTH-1:0] misr_next;
    logic             older_pending;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] taps);
        return x[0] ? ((x >> 1) ^ taps) : (x >> 1);
    endfunction

    always_comb begin
        misr_next     = step(signature, MISR_TAPS) ^ resp_in;
        // Any pattern still behind the top stage means the drain is not over.
        older_pending = 1'b0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            older_pending = older_pending | vpipe[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= '0;
            cnt       <= '0;
            vpipe     <= '0;
            pat_out   <= '0;
            signature <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else if (ena) begin
            vpipe <= vpipe << 1;
            if (vpipe[LATENCY]) begin
                signature <= misr_next;
            end
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        lfsr      <= SEED;
                        cnt       <= '0;
                        signature <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                RUN: begin
                    pat_out  <= lfsr;
                    lfsr     <= step(lfsr, LFSR_TAPS);
                    cnt      <= cnt + 1'b1;
                    vpipe[0] <= 1'b1;
                    if (cnt == LAST) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The final compaction lands on this same edge, so the
                    // verdict is taken from the next MISR value.
                    if (vpipe[LATENCY] && !older_pending) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (misr_next == expected_sig);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_bist_engine.sv
module tb_tt_bist_engine;

    localparam int          NP0  = 20;
    localparam int          LAT0 = 3;
    localparam logic [7:0]  TAPS = 8'hB8;
    localparam logic [7:0]  SEED = 8'h01;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // u0: random responses, NP0 patterns, LAT0 latency
    logic       rst0 = 1'b0, ena0 = 1'b1, start0 = 1'b0;
    logic [7:0] exp0 = '0, resp0 = '0;
    logic [7:0] pat0, sig0;
    logic       busy0, done0, pass0;

    // u1 (latency 0) and u2 (latency 2): loopback, 3 patterns, shared start
    logic       rst1 = 1'b0, rst2 = 1'b0, start_l = 1'b0;
    logic [7:0] exp_l = '0;
    logic [7:0] pat1, sig1, pat2, sig2, resp1, resp2;
    logic       busy1, done1, pass1, busy2, done2, pass2;
    logic [7:0] d1 = '0, d2 = '0;

    assign resp1 = pat1;
    always @(posedge clk) begin
        d1 <= pat2;
        d2 <= d1;
    end
    assign resp2 = d2;

    tt_bist_engine #(.WIDTH(8), .NUM_PATTERNS(NP0), .LATENCY(LAT0)) u0 (
        .clk(clk), .rst_n(rst0), .ena(ena0), .start(start0),
        .expected_sig(exp0), .resp_in(resp0), .pat_out(pat0),
        .busy(busy0), .done(done0), .pass(pass0), .signature(sig0));

    tt_bist_engine #(.WIDTH(8), .NUM_PATTERNS(3), .LATENCY(0)) u1 (
        .clk(clk), .rst_n(rst1), .ena(1'b1), .start(start_l),
        .expected_sig(exp_l), .resp_in(resp1), .pat_out(pat1),
        .busy(busy1), .done(done1), .pass(pass1), .signature(sig1));

    tt_bist_engine #(.WIDTH(8), .NUM_PATTERNS(3), .LATENCY(2)) u2 (
        .clk(clk), .rst_n(rst2), .ena(1'b1), .start(start_l),
        .expected_sig(exp_l), .resp_in(resp2), .pat_out(pat2),
        .busy(busy2), .done(done2), .pass(pass2), .signature(sig2));

    function automatic logic [7:0] nxt(input logic [7:0] x, input logic [7:0] t);
        return (x >> 1) ^ (x[0] ? t : 8'h00);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    logic [7:0] seq [6];
    logic [7:0] pat_model0 = 8'h00;

    // One u0 run with random responses; optional 5-cycle ena freeze at
    // effective cycle freeze_at. The model counts effective cycles k after
    // the start edge: pattern k shows for k in 1..NP0, and the response
    // driven in cycle k is compacted iff k is in [1+LAT0, NP0+LAT0].
    task automatic run0(input int freeze_at, input bit want_pass, input bit check_seq);
        int         k = 0;
        int         nfrozen = 0;
        logic [7:0] sm = 8'h00;
        logic [7:0] lm = SEED;
        logic [7:0] pm = pat_model0;
        start0 = 1'b1;
        ena0   = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("run0_busy_k0", busy0, 1);
        chk("run0_done_k0", done0, 0);
        chk("run0_pass_k0", pass0, 0);
        chk("run0_sig_k0", sig0, 0);
        while (k < NP0 + LAT0 + 1) begin
            if (k == freeze_at && nfrozen < 5) begin
                ena0 = 1'b0;
                nfrozen++;
            end else begin
                ena0 = 1'b1;
            end
            resp0  = 8'($urandom);
            start0 = (k < NP0 + LAT0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (ena0) begin
                if (k >= 1 + LAT0 && k <= NP0 + LAT0) sm = nxt(sm, TAPS) ^ resp0;
                if (k == NP0 + LAT0) exp0 = want_pass ? sm : (sm ^ 8'h01);
                k++;
                if (k <= NP0) begin
                    pm = lm;
                    lm = nxt(lm, TAPS);
                end
            end
            @(negedge clk);
            chk("run0_pat", pat0, pm);
            chk("run0_sig", sig0, sm);
            chk("run0_busy", busy0, (k <= NP0 + LAT0) ? 1 : 0);
            chk("run0_done", done0, (k == NP0 + LAT0 + 1) ? 1 : 0);
            chk("run0_pass", pass0, (k == NP0 + LAT0 + 1) ? want_pass : 0);
            if (check_seq && k >= 1 && k <= 6) chk("run0_seq", pat0, seq[k-1]);
        end
        start0     = 1'b0;
        ena0       = 1'b1;
        pat_model0 = pm;
    endtask

    // Loopback run on u1/u2: patterns 01,B8,5C give signature 5C.
    task automatic run_loop(input logic [7:0] e, input bit p);
        start_l = 1'b1;
        exp_l   = e;
        @(negedge clk);
        start_l = 1'b0;
        chk("loop_busy1_k0", busy1, 1);
        chk("loop_busy2_k0", busy2, 1);
        chk("loop_done1_k0", done1, 0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("loop_pat1", pat1, (k <= 3) ? seq[k-1] : 8'h5C);
            chk("loop_pat2", pat2, (k <= 3) ? seq[k-1] : 8'h5C);
            chk("loop_done1", done1, (k >= 4) ? 1 : 0);
            chk("loop_done2", done2, (k >= 6) ? 1 : 0);
            if (k >= 4) begin
                chk("loop_sig1", sig1, 8'h5C);
                chk("loop_pass1", pass1, p);
            end
            if (k == 6) begin
                chk("loop_sig2", sig2, 8'h5C);
                chk("loop_pass2", pass2, p);
            end
        end
    endtask

    initial begin
        seq[0] = 8'h01; seq[1] = 8'hB8; seq[2] = 8'h5C;
        seq[3] = 8'h2E; seq[4] = 8'h17; seq[5] = 8'hB3;

        // Reset with start held high
        start0 = 1'b1;
        start_l = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pat0", pat0, 0);
        chk("rst_sig0", sig0, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_pass0", pass0, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_busy2", busy2, 0);
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        start0 = 1'b0; start_l = 1'b0;
        @(negedge clk);
        chk("idle_busy0", busy0, 0);
        chk("idle_done0", done0, 0);

        // Random-response runs: pass, restart from DONE with fail, ena freeze
        run0(-1, 1'b1, 1'b1);
        run0(-1, 1'b0, 1'b0);
        run0(7, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("hold_done0", done0, 1);
        chk("hold_pass0", pass0, 1);

        // Loopback, latency 0 and 2
        run_loop(8'h5C, 1'b1);
        run_loop(8'h5D, 1'b0);

        // Abort u1 mid-run at cnt=2
        start_l = 1'b1;
        exp_l   = 8'h5C;
        @(negedge clk);
        start_l = 1'b0;
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        chk("abort_busy1", busy1, 0);
        chk("abort_done1", done1, 0);
        chk("abort_sig1", sig1, 0);
        chk("abort_pat1", pat1, 0);
        rst1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_nodone1", done1, 0);
        end
        run_loop(8'h5C, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
